// File: rtl/fir_mac_seq.sv
// fir_mac_seq - sequential FIR filter with one shared multiplier.
//
// Holds NUM_TAPS samples x[] and coefficients h[]. Each accepted sample shifts
// the delay line and then spends NUM_TAPS cycles accumulating x[k]*h[k]. The
// final sum is rounded half-up and saturated to Q1.(DATA_WIDTH-1).
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_valid/o_ready     input sample handshake, iv_din = signed sample
//   o_valid/i_ready     output handshake, ov_dout = signed filtered sample
//   i_coef_wr           coefficient write strobe (honoured only while idle)
//   iv_coef_addr        tap index, 0 multiplies the newest sample
//   iv_coef             signed coefficient
//   o_sat / i_clr_sat   sticky saturation flag and its clear
module fir_mac_seq #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [DATA_WIDTH-1:0] iv_din,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  input  logic                         i_coef_wr,
  input  logic        [ADDR_WIDTH-1:0] iv_coef_addr,
  input  logic signed [DATA_WIDTH-1:0] iv_coef,
  output logic                         o_sat,
  input  logic                         i_clr_sat
);

  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_TAPS);
  localparam int PROD_WIDTH = 2*DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH:0]   TAPS_W   = (ADDR_WIDTH+1)'(NUM_TAPS);

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  localparam logic signed [ACC_WIDTH-1:0] RND_C =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, 1'b1, {(DATA_WIDTH-2){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x_d [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  h_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  h_d [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                          valid_q, valid_d;
  logic                          sat_q, sat_d;

  logic signed [PROD_WIDTH-1:0]  prod_s;
  logic signed [ACC_WIDTH-1:0]   prod_ext_s;
  logic signed [ACC_WIDTH-1:0]   acc_sum_s;
  logic signed [ACC_WIDTH-1:0]   acc_rnd_s;
  logic signed [ACC_WIDTH-1:0]   r_s;
  logic                          sat_hi_s;
  logic                          sat_lo_s;
  logic signed [DATA_WIDTH-1:0]  dout_sat_s;
  logic                          sat_set_s;

  // Shared MAC datapath plus rounding and saturation of the running sum.
  always_comb begin
    prod_s     = x_q[idx_q] * h_q[idx_q];
    prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
    acc_sum_s  = acc_q + prod_ext_s;
    acc_rnd_s  = acc_sum_s + RND_C;
    r_s        = acc_rnd_s >>> (DATA_WIDTH-1);
    sat_hi_s   = (r_s > SAT_MAX);
    sat_lo_s   = (r_s < SAT_MIN);
    if (sat_hi_s) begin
      dout_sat_s = OUT_MAX;
    end else if (sat_lo_s) begin
      dout_sat_s = OUT_MIN;
    end else begin
      dout_sat_s = r_s[DATA_WIDTH-1:0];
    end
  end

  // Next-state logic for the FSM, delay line, coefficients and outputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    h_d       = h_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    sat_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Coefficient writes land even on the accept edge, so the MAC that
        // follows already sees the new value.
        if (i_coef_wr && ({1'b0, iv_coef_addr} < TAPS_W)) begin
          h_d[iv_coef_addr] = iv_coef;
        end else begin
          h_d = h_q;
        end
        if (i_valid) begin
          x_d[0] = iv_din;
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = {ACC_WIDTH{1'b0}};
          idx_d   = {ADDR_WIDTH{1'b0}};
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum_s;
        if (idx_q == LAST_IDX) begin
          idx_d     = {ADDR_WIDTH{1'b0}};
          state_d   = ST_OUT;
          dout_d    = dout_sat_s;
          valid_d   = 1'b1;
          sat_set_s = sat_hi_s | sat_lo_s;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_OUT: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // A new saturation event beats a simultaneous clear.
    if (sat_set_s) begin
      sat_d = 1'b1;
    end else if (i_clr_sat) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // State registers with synchronous reset; reset aborts any MAC in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= {DATA_WIDTH{1'b0}};
        h_q[k] <= {DATA_WIDTH{1'b0}};
      end
      acc_q   <= {ACC_WIDTH{1'b0}};
      idx_q   <= {ADDR_WIDTH{1'b0}};
      dout_q  <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= x_d[k];
        h_q[k] <= h_d[k];
      end
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = valid_q;
  assign ov_dout = dout_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq (8-bit data, 16 taps, plus a 12-tap
// instance for the out-of-range coefficient address case).
module tb_fir_mac_seq;

  localparam int DW  = 8;
  localparam int NT  = 16;
  localparam int AW  = 4;
  localparam int NTB = 12;
  localparam int AWB = 4;

  logic                 clk;
  logic                 i_rst;
  logic                 i_valid, o_ready, o_valid, i_ready;
  logic signed [DW-1:0] iv_din, ov_dout, iv_coef;
  logic                 i_coef_wr, o_sat, i_clr_sat;
  logic        [AW-1:0] iv_coef_addr;

  logic                 i_valid_b, o_ready_b, o_valid_b;
  logic signed [DW-1:0] iv_din_b, ov_dout_b, iv_coef_b;
  logic                 i_coef_wr_b, o_sat_b;
  logic       [AWB-1:0] iv_coef_addr_b;

  fir_mac_seq #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_WIDTH(AW)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .iv_din(iv_din), .o_valid(o_valid), .i_ready(i_ready), .ov_dout(ov_dout),
    .i_coef_wr(i_coef_wr), .iv_coef_addr(iv_coef_addr), .iv_coef(iv_coef),
    .o_sat(o_sat), .i_clr_sat(i_clr_sat)
  );

  fir_mac_seq #(.DATA_WIDTH(DW), .NUM_TAPS(NTB), .ADDR_WIDTH(AWB)) u_dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid_b), .o_ready(o_ready_b),
    .iv_din(iv_din_b), .o_valid(o_valid_b), .i_ready(1'b1), .ov_dout(ov_dout_b),
    .i_coef_wr(i_coef_wr_b), .iv_coef_addr(iv_coef_addr_b), .iv_coef(iv_coef_b),
    .o_sat(o_sat_b), .i_clr_sat(1'b0)
  );

  typedef struct {
    int dout;
    int sat;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mx [NT];
  int   mh [NT];
  int   msat;
  int   n_checks;
  int   n_errors;
  int   cyc;
  bit   prev_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      mx[k] = 0;
      mh[k] = 0;
    end
    msat = 0;
  endtask

  // Drive one sample when the DUT is ready; push the reference result.
  task automatic send_sample(input int v);
    exp_t e;
    int   acc;
    int   r;
    @(negedge clk);
    for (int t = 0; t < 200 && !o_ready; t++) @(negedge clk);
    check_eq("ready_wait", o_ready, 1);
    i_valid = 1'b1;
    iv_din  = v[DW-1:0];
    for (int k = NT-1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = v;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += mx[k] * mh[k];
    r = (acc + (1 << (DW-2))) >>> (DW-1);
    if (r > 127) begin
      r = 127;
      msat = 1;
    end else if (r < -128) begin
      r = -128;
      msat = 1;
    end
    e.dout    = r;
    e.sat     = msat;
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v, input bit eff);
    @(negedge clk);
    i_coef_wr    = 1'b1;
    iv_coef_addr = a[AW-1:0];
    iv_coef      = v[DW-1:0];
    if (eff) mh[a] = v;
    @(negedge clk);
    i_coef_wr = 1'b0;
  endtask

  task automatic write_coef_b(input int a, input int v);
    @(negedge clk);
    i_coef_wr_b    = 1'b1;
    iv_coef_addr_b = a[AWB-1:0];
    iv_coef_b      = v[DW-1:0];
    @(negedge clk);
    i_coef_wr_b = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400 && (exp_q.size() != 0 || !o_ready); t++) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Output monitor: latency on each rising o_valid, value on each handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (i_rst) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid && !prev_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_valid", o_valid, 0);
        else check_eq("latency", cyc - exp_q[0].acc_cyc, NT);
      end
      if (o_valid && i_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("dout", ov_dout, e.dout);
        check_eq("sat", o_sat, e.sat);
      end
      prev_valid = o_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int din_v;
    n_checks = 0; n_errors = 0; cyc = 0; prev_valid = 1'b0;
    i_rst = 1'b1; i_valid = 1'b0; iv_din = '0; i_ready = 1'b1;
    i_coef_wr = 1'b0; iv_coef_addr = '0; iv_coef = '0; i_clr_sat = 1'b0;
    i_valid_b = 1'b0; iv_din_b = '0; i_coef_wr_b = 1'b0;
    iv_coef_addr_b = '0; iv_coef_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_dout", ov_dout, 0);
    check_eq("rst_sat", o_sat, 0);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_ready_b", o_ready_b, 1);

    // Impulse response.
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
    send_sample(-128);
    for (int j = 0; j < 20; j++) send_sample(0);
    wait_idle();

    // Positive and negative saturation, then clear.
    for (int k = 0; k < NT; k++) write_coef(k, 127, 1'b1);
    for (int j = 0; j < 16; j++) send_sample(127);
    for (int j = 0; j < 16; j++) send_sample(-128);
    wait_idle();
    check_eq("sat_before_clr", o_sat, 1);
    @(negedge clk);
    i_clr_sat = 1'b1;
    @(negedge clk);
    i_clr_sat = 1'b0;
    msat = 0;
    check_eq("sat_cleared", o_sat, 0);

    // Rounding half-up.
    write_coef(0, 1, 1'b1);
    for (int k = 1; k < NT; k++) write_coef(k, 0, 1'b1);
    send_sample(64);
    send_sample(-64);
    send_sample(63);
    wait_idle();

    // Backpressure: output held, no sample accepted while stalled.
    i_ready = 1'b0;
    send_sample(40);
    for (int t = 0; t < 40 && !o_valid; t++) @(negedge clk);
    check_eq("bp_valid", o_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_dout", ov_dout, exp_q[0].dout);
      check_eq("bp_ready", o_ready, 0);
      check_eq("bp_hold", o_valid, 1);
      i_valid = 1'b1;
      iv_din  = 8'sd77;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_valid_drop", o_valid, 0);
    check_eq("bp_ready_back", o_ready, 1);
    check_eq("bp_drain", exp_q.size(), 0);
    @(negedge clk);
    check_eq("bp_no_accept", o_ready, 1);

    // Coefficient write while busy is ignored.
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
    send_sample(50);
    write_coef(0, 100, 1'b0);
    send_sample(30);
    wait_idle();

    // Reset mid-MAC aborts the sample and clears coefficients.
    send_sample(-128);
    repeat (4) @(negedge clk);
    i_rst = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    check_eq("mid_rst_valid", o_valid, 0);
    check_eq("mid_rst_dout", ov_dout, 0);
    check_eq("mid_rst_sat", o_sat, 0);
    check_eq("mid_rst_ready", o_ready, 1);
    send_sample(-128);
    wait_idle();

    // 12-tap instance: writes to addresses 12..15 must change nothing.
    for (int k = 0; k < NTB; k++) write_coef_b(k, k + 1);
    for (int k = NTB; k < 16; k++) write_coef_b(k, 100);
    for (int j = 0; j < NTB + 2; j++) begin
      @(negedge clk);
      for (int t = 0; t < 40 && !o_ready_b; t++) @(negedge clk);
      din_v     = (j == 0) ? -128 : 0;
      i_valid_b = 1'b1;
      iv_din_b  = din_v[DW-1:0];
      @(negedge clk);
      i_valid_b = 1'b0;
      for (int t = 0; t < 40 && !o_valid_b; t++) @(negedge clk);
      check_eq("b_dout", ov_dout_b, (j < NTB) ? -(j + 1) : 0);
    end
    check_eq("b_sat", o_sat_b, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
